// File: rtl/phoenix_input_buffer_pkg.sv
// Shared constants and FSM encoding for the Phoenix router input buffer.
package phoenix_input_buffer_pkg;

    localparam int unsigned TAM_FLIT   = 16;
    localparam int unsigned TAM_BUFFER = 16;
    localparam int unsigned PTR_W      = 4;
    localparam int unsigned NPORT      = 5;

    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HDR  = 3'd2,
        S_SIZE = 3'd3,
        S_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/phoenix_input_buffer_fifo.sv
// Credit-flow-controlled flit FIFO: storage, wrapping pointers, occupancy and credit.
module phoenix_input_buffer_fifo
    import phoenix_input_buffer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_i,
    input  logic [TAM_FLIT-1:0] wr_data_i,
    input  logic                rd_i,
    output logic [TAM_FLIT-1:0] head_o,
    output logic [PTR_W:0]      count_o,
    output logic                credit_o
);

    localparam logic [PTR_W:0] CountFull = (PTR_W+1)'(TAM_BUFFER);

    logic [TAM_FLIT-1:0] mem_q [TAM_BUFFER];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic                wr_en, rd_en;

    assign credit_o = (count_q != CountFull);
    // Writes without credit and reads from an empty FIFO are dropped here.
    assign wr_en    = wr_i && credit_o;
    assign rd_en    = rd_i && (count_q != '0);
    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/phoenix_input_buffer.sv
// Phoenix router input port: buffers link flits, requests a route, streams the packet out.
module phoenix_input_buffer
    import phoenix_input_buffer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                data_ack,
    output logic                sender
);

    state_e              state_q;
    logic [TAM_FLIT-1:0] flit_cnt_q;
    logic                h_q, sender_q;
    logic [TAM_FLIT-1:0] head;
    logic [PTR_W:0]      count;
    logic                pop, streaming;

    phoenix_input_buffer_fifo u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_i      (rx),
        .wr_data_i (data_in),
        .rd_i      (pop),
        .head_o    (head),
        .count_o   (count),
        .credit_o  (credit_o)
    );

    assign streaming = (state_q == S_HDR) || (state_q == S_SIZE) || (state_q == S_DATA);
    // data_av tracks occupancy combinationally so an underrun stalls without losing state.
    assign data_av   = streaming && (count != '0);
    assign pop       = data_av && data_ack;
    assign data_out  = data_av ? head : '0;
    assign h         = h_q;
    assign sender    = sender_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            flit_cnt_q <= '0;
            h_q        <= 1'b0;
            sender_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count != '0) begin
                        state_q <= S_REQ;
                        h_q     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_h) begin
                        state_q  <= S_HDR;
                        h_q      <= 1'b0;
                        sender_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (pop) state_q <= S_SIZE;
                end
                S_SIZE: begin
                    if (pop) begin
                        flit_cnt_q <= data_out;
                        if (data_out == '0) begin
                            state_q  <= S_IDLE;
                            sender_q <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (pop) begin
                        flit_cnt_q <= flit_cnt_q - 1'b1;
                        if (flit_cnt_q == TAM_FLIT'(1)) begin
                            state_q  <= S_IDLE;
                            sender_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    h_q      <= 1'b0;
                    sender_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
